// File: rtl/display_arbiter.sv
// display_arbiter
//   Decides who owns the shared 4-digit 7-segment display: the free-running
//   clock, one of four service blocks, or the alarm. The alarm preempts all
//   other owners. Also drives the digit scan (active-low anode plus BCD digit)
//   and blinks the edited digit while S1 (time set) or S2 (alarm set) owns
//   the display.
// Ports
//   clk, resetn        rising-edge clock, synchronous active-low reset
//   req[3:0]           service request levels ([3]=S1 .. [0]=S4)
//   done[3:0]          one-cycle finish pulses, same bit order as req
//   alarm_ring         alarm level; preempts every other owner
//   num_clk, num_s1..4 4-digit BCD display sources ([3:0] = rightmost digit)
//   sel_s1, sel_s2     one-hot edited-digit select for S1 / S2
//   grant[3:0]         one-hot current owner, 0 when there is none
//   conflict           IDLE with more than one eligible request
//   anode[3:0]         active-low digit enable
//   digit[3:0]         BCD value for the enabled digit
module display_arbiter #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic        alarm_ring,
  input  logic [15:0] num_clk,
  input  logic [15:0] num_s1,
  input  logic [15:0] num_s2,
  input  logic [15:0] num_s3,
  input  logic [15:0] num_s4,
  input  logic [3:0]  sel_s1,
  input  logic [3:0]  sel_s2,
  output logic [3:0]  grant,
  output logic        conflict,
  output logic [3:0]  anode,
  output logic [3:0]  digit
);

  localparam int DW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE, ALARM} state_t;

  state_t        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic          conflict_q, conflict_d;
  logic [3:0]    lock_q, lock_d;
  logic [3:0]    anode_q, anode_d;
  logic [3:0]    digit_q, digit_d;
  logic [1:0]    idx_q, idx_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;

  logic [3:0]    elig, lock_set;
  logic          one_elig, multi_elig;
  logic          div_wrap, frame_adv, frame_wrap, blank;
  logic [15:0]   src;

  // Ownership FSM and lockout
  always_comb begin
    elig       = req & ~lock_q;
    one_elig   = (elig != 4'd0) && ((elig & (elig - 4'd1)) == 4'd0);
    multi_elig = (elig != 4'd0) && !one_elig;
    state_d    = state_q;
    grant_d    = grant_q;
    conflict_d = 1'b0;
    lock_set   = 4'd0;
    unique case (state_q)
      IDLE: begin
        grant_d = 4'd0;
        if (alarm_ring) state_d = ALARM;
        else if (one_elig) begin
          state_d = GRANT;
          grant_d = elig;
        end else conflict_d = multi_elig;
      end
      GRANT: begin
        // A finish pulse from the owner locks it even when the alarm wins.
        lock_set = done & grant_q;
        if (alarm_ring) begin
          state_d = ALARM;
          grant_d = 4'd0;
        end else if (lock_set != 4'd0 || (req & grant_q) == 4'd0) begin
          state_d = RELEASE;
          grant_d = 4'd0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = 4'd0;
      end
      ALARM: begin
        grant_d = 4'd0;
        if (!alarm_ring) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'd0;
      end
    endcase
    // A lowered request always clears its lock, including in the setting cycle.
    lock_d = (lock_q | lock_set) & req;
  end

  // Digit scan and blink timing
  always_comb begin
    div_wrap    = (div_cnt_q == DW'(SCAN_DIV - 1));
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
    idx_d       = div_wrap ? idx_q + 2'd1 : idx_q;
    frame_adv   = div_wrap && (idx_q == 2'd3);
    frame_wrap  = frame_adv && (frame_cnt_q == FW'(BLINK_DIV - 1));
    frame_cnt_d = frame_adv ? (frame_wrap ? '0 : frame_cnt_q + 1'b1) : frame_cnt_q;
    blink_d     = blink_q ^ frame_wrap;

    src = num_clk;
    if (state_q == ALARM) src = 16'h8888;
    else if (state_q == GRANT) begin
      unique case (grant_q)
        4'b1000: src = num_s1;
        4'b0100: src = num_s2;
        4'b0010: src = num_s3;
        4'b0001: src = num_s4;
        default: src = num_clk;
      endcase
    end

    // grant_q is only nonzero in GRANT, so no extra state test is needed.
    blank = blink_q && ((state_q == ALARM) ||
                        (grant_q[3] && sel_s1[idx_q]) ||
                        (grant_q[2] && sel_s2[idx_q]));

    // The slot is latched at the wrap edge, so a source change waits for it.
    anode_d = anode_q;
    digit_d = digit_q;
    if (div_wrap) begin
      anode_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
      digit_d = src[{idx_q, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= 4'd0;
      conflict_q  <= 1'b0;
      lock_q      <= 4'd0;
      anode_q     <= 4'b1111;
      digit_q     <= 4'd0;
      idx_q       <= 2'd0;
      div_cnt_q   <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      conflict_q  <= conflict_d;
      lock_q      <= lock_d;
      anode_q     <= anode_d;
      digit_q     <= digit_d;
      idx_q       <= idx_d;
      div_cnt_q   <= div_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign grant    = grant_q;
  assign conflict = conflict_q;
  assign anode    = anode_q;
  assign digit    = digit_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter. dut_a (SCAN_DIV=2, BLINK_DIV=2) covers the scan,
// the arbitration sequences and the alarm. dut_b (SCAN_DIV=1, BLINK_DIV=1)
// shares the same inputs and covers the edited-digit blink.
module tb_display_arbiter;

  logic        clk, resetn, alarm_ring;
  logic [3:0]  req, done, sel_s1, sel_s2;
  logic [15:0] num_clk, num_s1, num_s2, num_s3, num_s4;
  logic [3:0]  grant_a, anode_a, digit_a, grant_b, anode_b, digit_b;
  logic        conflict_a, conflict_b;

  int n_chk = 0;
  int n_err = 0;

  display_arbiter #(.SCAN_DIV(2), .BLINK_DIV(2)) dut_a (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .alarm_ring(alarm_ring),
    .num_clk(num_clk), .num_s1(num_s1), .num_s2(num_s2), .num_s3(num_s3),
    .num_s4(num_s4), .sel_s1(sel_s1), .sel_s2(sel_s2),
    .grant(grant_a), .conflict(conflict_a), .anode(anode_a), .digit(digit_a)
  );

  display_arbiter #(.SCAN_DIV(1), .BLINK_DIV(1)) dut_b (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .alarm_ring(alarm_ring),
    .num_clk(num_clk), .num_s1(num_s1), .num_s2(num_s2), .num_s3(num_s3),
    .num_s4(num_s4), .sel_s1(sel_s1), .sel_s2(sel_s2),
    .grant(grant_b), .conflict(conflict_b), .anode(anode_b), .digit(digit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] exp_grant;
    logic       exp_conflict;
  } vec_t;

  vec_t tbl[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Eight dut_a cycles = one full frame; every slot must show src's nibble.
  task automatic scan_check(input logic [15:0] src, input string nm);
    logic [3:0] seen, cold;
    int k;
    seen = 4'd0;
    repeat (8) begin
      tick();
      k = -1;
      for (int i = 0; i < 4; i++) begin
        cold = ~(4'b0001 << i);
        if (anode_a == cold) k = i;
      end
      if (k < 0) chk({nm, " anode one-cold"}, {12'd0, anode_a}, 16'h000E);
      else begin
        chk({nm, " digit"}, {12'd0, digit_a}, {12'd0, src[4*k +: 4]});
        seen[k] = 1'b1;
      end
    end
    chk({nm, " all slots"}, {12'd0, seen}, 16'h000F);
  endtask

  initial begin
    int dark, lit, c_e, c_d, c_b, c_7, c_f;
    resetn = 1'b0; req = 4'd0; done = 4'd0; alarm_ring = 1'b0;
    sel_s1 = 4'd0; sel_s2 = 4'd0;
    num_clk = 16'h1234; num_s1 = 16'h5678; num_s2 = 16'h9AB0;
    num_s3 = 16'h4321; num_s4 = 16'h0F0E;

    // Reset and idle scan
    repeat (2) tick();
    chk("reset grant",    {12'd0, grant_a}, 16'h0);
    chk("reset conflict", {15'd0, conflict_a}, 16'h0);
    chk("reset anode",    {12'd0, anode_a}, 16'h000F);
    chk("reset digit",    {12'd0, digit_a}, 16'h0);
    resetn = 1'b1;
    tick();
    chk("scan dark before first slot", {12'd0, anode_a}, 16'h000F);
    for (int t = 2; t <= 10; t++) begin
      int s;
      logic [3:0] ea;
      tick();
      s  = ((t / 2) - 1) % 4;
      ea = ~(4'b0001 << s);
      chk($sformatf("idle scan anode t%0d", t), {12'd0, anode_a}, {12'd0, ea});
      chk($sformatf("idle scan digit t%0d", t), {12'd0, digit_a}, {12'd0, num_clk[4*s +: 4]});
      chk($sformatf("idle grant t%0d", t), {12'd0, grant_a}, 16'h0);
    end

    // Arbitration vectors: one per cycle from IDLE with no locks
    tbl[0]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0};  // single grant
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0};  // done -> RELEASE, lock
    tbl[3]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0};  // IDLE
    tbl[4]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0};  // still locked
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0};  // lowering clears lock
    tbl[6]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0};  // re-granted
    tbl[7]  = '{4'b0100, 4'b0001, 4'b0100, 1'b0};  // non-owner done ignored
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0};  // req drop -> RELEASE
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0};  // RELEASE -> IDLE
    tbl[10] = '{4'b0001, 4'b0000, 4'b0001, 1'b0};  // bit 0 was never locked
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[13] = '{4'b1010, 4'b0000, 4'b0000, 1'b1};  // conflict
    tbl[14] = '{4'b1010, 4'b0000, 4'b0000, 1'b1};
    tbl[15] = '{4'b0010, 4'b0000, 4'b0010, 1'b0};  // conflict resolved
    tbl[16] = '{4'b0010, 4'b0000, 4'b0010, 1'b0};
    tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    for (int v = 0; v < 19; v++) begin
      req  = tbl[v].req;
      done = tbl[v].done;
      tick();
      chk($sformatf("vec%0d grant", v), {12'd0, grant_a}, {12'd0, tbl[v].exp_grant});
      chk($sformatf("vec%0d conflict", v), {15'd0, conflict_a}, {15'd0, tbl[v].exp_conflict});
    end
    done = 4'd0;

    // S2 owns: display shows num_s2 (including digits above 9)
    req = 4'b0100;
    tick();
    chk("s2 grant", {12'd0, grant_a}, 16'h0004);
    repeat (2) tick();
    scan_check(num_s2, "s2 display");
    req = 4'd0;
    repeat (2) tick();

    // Conflict keeps the clock on the display
    req = 4'b1010;
    tick();
    chk("conflict flag", {15'd0, conflict_a}, 16'h1);
    repeat (2) tick();
    scan_check(num_clk, "conflict display");
    chk("conflict grant", {12'd0, grant_a}, 16'h0);
    req = 4'd0;
    repeat (2) tick();

    // Alarm preemption of S3
    req = 4'b0010;
    tick();
    chk("s3 grant", {12'd0, grant_a}, 16'h0002);
    repeat (2) tick();
    scan_check(num_s3, "s3 display");
    alarm_ring = 1'b1;
    tick();
    chk("alarm grant cleared", {12'd0, grant_a}, 16'h0);
    repeat (2) tick();
    dark = 0; lit = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      chk($sformatf("alarm digit c%0d", c), {12'd0, digit_a}, 16'h0008);
      if (anode_a == 4'b1111) dark++; else lit++;
    end
    chk("alarm dark cycles", dark[15:0], 16'd16);
    chk("alarm lit cycles", lit[15:0], 16'd16);
    alarm_ring = 1'b0;
    tick();
    chk("alarm exit idle", {12'd0, grant_a}, 16'h0);
    tick();
    chk("s3 regrant after alarm", {12'd0, grant_a}, 16'h0002);

    // alarm and done together: alarm wins, lock still set
    alarm_ring = 1'b1; done = 4'b0010;
    tick();
    chk("alarm+done grant", {12'd0, grant_a}, 16'h0);
    alarm_ring = 1'b0; done = 4'd0;
    repeat (2) tick();
    chk("alarm+done locked", {12'd0, grant_a}, 16'h0);
    req = 4'd0;
    tick();
    req = 4'b0010;
    tick();
    chk("unlock after lower", {12'd0, grant_a}, 16'h0002);
    req = 4'd0;
    repeat (2) tick();

    // Reset mid-grant: S4 owns while S1 is locked
    req = 4'b1000;
    tick();
    chk("s1 grant", {12'd0, grant_a}, 16'h0008);
    done = 4'b1000;
    tick();
    done = 4'd0; req = 4'b1001;
    repeat (2) tick();
    chk("s4 owns with s1 locked", {12'd0, grant_a}, 16'h0001);
    sel_s1 = 4'b0100;
    resetn = 1'b0; req = 4'b1000;
    tick();
    chk("mid reset grant",    {12'd0, grant_a}, 16'h0);
    chk("mid reset conflict", {15'd0, conflict_a}, 16'h0);
    chk("mid reset anode",    {12'd0, anode_a}, 16'h000F);
    chk("mid reset digit",    {12'd0, digit_a}, 16'h0);
    resetn = 1'b1;
    tick();
    chk("s1 grant after reset", {12'd0, grant_b}, 16'h0008);

    // Edit blink on dut_b: digit 2 of S1 dark in alternate frames only
    c_e = 0; c_d = 0; c_b = 0; c_7 = 0; c_f = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      unique case (anode_b)
        4'b1110: c_e++;
        4'b1101: c_d++;
        4'b1011: c_b++;
        4'b0111: c_7++;
        4'b1111: begin
          c_f++;
          chk($sformatf("blink dark digit c%0d", c), {12'd0, digit_b}, {12'd0, num_s1[11:8]});
        end
        default: chk("blink anode valid", {12'd0, anode_b}, 16'h000F);
      endcase
    end
    chk("blink slot0 count", c_e[15:0], 16'd4);
    chk("blink slot1 count", c_d[15:0], 16'd4);
    chk("blink slot2 lit",   c_b[15:0], 16'd2);
    chk("blink slot2 dark",  c_f[15:0], 16'd2);
    chk("blink slot3 count", c_7[15:0], 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
